// File: rtl/ysyx_23060208_ifetch.sv
// Instruction fetch: owns the PC, issues one AR/R read per instruction and buffers it for decode.
// Latency: AR (1) + SRAM read + OUT (1) cycles per instruction; decode stalls hold S_OUT, and redirects cancel in-flight reads.
module ysyx_23060208_ifetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] isram_araddr,
    output logic                  isram_arvalid,
    input  logic                  isram_arready,
    input  logic [1:0]            isram_rresp,
    input  logic                  isram_rvalid,
    input  logic [DATA_WIDTH-1:0] isram_rdata,
    output logic                  isram_rready,
    output logic                  ifu_allowin,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  to_idu_valid,
    output logic [DATA_WIDTH-1:0] to_idu_inst,
    output logic [DATA_WIDTH-1:0] to_idu_pc,
    output logic                  to_idu_err,
    input  logic                  idu_allowin
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pend_pc_q;
    logic                  kill_q;
    logic [DATA_WIDTH-1:0] inst_q;
    logic [DATA_WIDTH-1:0] pc_out_q;
    logic                  err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            kill_q    <= 1'b0;
            inst_q    <= '0;
            pc_out_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_AR;
                S_AR: begin
                    // pc stays put so araddr is stable while the request is offered
                    if (redirect_valid) begin
                        pend_pc_q <= redirect_pc;
                        kill_q    <= 1'b1;
                    end
                    if (isram_arready) begin
                        state_q <= S_R;
                    end
                end
                S_R: begin
                    if (isram_rvalid) begin
                        if (!kill_q && !redirect_valid) begin
                            inst_q   <= isram_rdata;
                            pc_out_q <= pc_q;
                            err_q    <= (isram_rresp != 2'b00);
                            state_q  <= S_OUT;
                        end else begin
                            // wrong-path beat: drop it and restart at the newest target
                            pc_q    <= redirect_valid ? redirect_pc : pend_pc_q;
                            kill_q  <= 1'b0;
                            state_q <= S_AR;
                        end
                    end else if (redirect_valid) begin
                        pend_pc_q <= redirect_pc;
                        kill_q    <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        state_q <= S_AR;
                    end else if (idu_allowin) begin
                        pc_q    <= pc_q + DATA_WIDTH'(4);
                        state_q <= S_AR;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign isram_araddr  = pc_q;
    assign isram_arvalid = (state_q == S_AR);
    assign isram_rready  = (state_q == S_R);
    assign to_idu_valid  = (state_q == S_OUT);
    assign ifu_allowin   = (state_q != S_OUT);
    assign to_idu_inst   = inst_q;
    assign to_idu_pc     = pc_out_q;
    assign to_idu_err    = err_q;

endmodule

// File: tb/tb_ysyx_23060208_ifetch.sv
// Directed bench: behavioural SRAM slave, transfer scoreboard and AR address log.
module tb_ysyx_23060208_ifetch;

    logic        clk;
    logic        rst;
    logic [31:0] isram_araddr;
    logic        isram_arvalid;
    logic        isram_arready;
    logic [1:0]  isram_rresp;
    logic        isram_rvalid;
    logic [31:0] isram_rdata;
    logic        isram_rready;
    logic        ifu_allowin;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        to_idu_valid;
    logic [31:0] to_idu_inst;
    logic [31:0] to_idu_pc;
    logic        to_idu_err;
    logic        idu_allowin;

    ysyx_23060208_ifetch #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h8000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .isram_araddr  (isram_araddr),
        .isram_arvalid (isram_arvalid),
        .isram_arready (isram_arready),
        .isram_rresp   (isram_rresp),
        .isram_rvalid  (isram_rvalid),
        .isram_rdata   (isram_rdata),
        .isram_rready  (isram_rready),
        .ifu_allowin   (ifu_allowin),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .to_idu_valid  (to_idu_valid),
        .to_idu_inst   (to_idu_inst),
        .to_idu_pc     (to_idu_pc),
        .to_idu_err    (to_idu_err),
        .idu_allowin   (idu_allowin)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } tx_t;

    tx_t         exp_tx[$];
    logic [31:0] ar_log[$];
    int          cmp_cnt = 0;
    int          err_cnt = 0;

    int          rlat     = 1;
    logic [31:0] err_addr = 32'h8000_0004;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp)
        else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic [31:0] pc, input logic err);
        tx_t t;
        t.pc   = pc;
        t.inst = mem(pc);
        t.err  = err;
        exp_tx.push_back(t);
    endtask

    task automatic chk_ar(input logic [31:0] exp);
        logic [31:0] a;
        chk("ar_present", 32'(ar_log.size() != 0), 32'd1);
        if (ar_log.size() != 0) begin
            a = ar_log.pop_front();
            chk("ar_addr", a, exp);
        end
    endtask

    // sel=1 waits for rready, sel=0 for to_idu_valid; expiry counts as a failure
    task automatic wait_sig(input string tag, input bit sel);
        int n = 0;
        while (!(sel ? isram_rready : to_idu_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sel ? isram_rready : to_idu_valid), 32'd1);
    endtask

    task automatic get_one();
        wait_sig("wait_valid", 1'b0);
        idu_allowin = 1'b1;
        @(negedge clk);
        idu_allowin = 1'b0;
    endtask

    // Behavioural SRAM slave: one outstanding read, rlat cycles to rvalid
    bit          s_busy;
    logic [31:0] s_addr;
    int          s_cnt;
    bit          s_ar_hs;
    bit          s_r_hs;
    logic [31:0] s_ar_a;
    initial begin
        s_busy = 0; s_cnt = 0; s_ar_hs = 0; s_r_hs = 0; s_addr = '0; s_ar_a = '0;
        isram_rvalid = 1'b0;
        isram_rdata  = '0;
        isram_rresp  = 2'b00;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                s_busy = 0;
                isram_rvalid = 1'b0;
            end else begin
                if (s_r_hs) begin
                    s_busy = 0;
                    isram_rvalid = 1'b0;
                end
                if (s_ar_hs) begin
                    s_busy = 1;
                    s_addr = s_ar_a;
                    s_cnt  = rlat;
                end
                if (s_busy && !isram_rvalid) begin
                    if (s_cnt <= 1) begin
                        isram_rvalid = 1'b1;
                        isram_rdata  = mem(s_addr);
                        isram_rresp  = (s_addr == err_addr) ? 2'b10 : 2'b00;
                    end else begin
                        s_cnt--;
                    end
                end
            end
            #1;
            s_ar_hs = !rst && isram_arvalid && isram_arready;
            s_ar_a  = isram_araddr;
            s_r_hs  = !rst && isram_rvalid && isram_rready;
        end
    end

    // Monitor: log AR handshakes, score every accepted transfer
    tx_t mt;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (isram_arvalid && isram_arready) ar_log.push_back(isram_araddr);
                if (to_idu_valid && idu_allowin && !redirect_valid) begin
                    chk("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
                    if (exp_tx.size() != 0) begin
                        mt = exp_tx.pop_front();
                        chk("tx_pc", to_idu_pc, mt.pc);
                        chk("tx_inst", to_idu_inst, mt.inst);
                        chk("tx_err", 32'(to_idu_err), 32'(mt.err));
                    end
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        idu_allowin    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        isram_arready  = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_arvalid", 32'(isram_arvalid), 32'd0);
        chk("rst_rready", 32'(isram_rready), 32'd0);
        chk("rst_valid", 32'(to_idu_valid), 32'd0);
        chk("rst_allowin", 32'(ifu_allowin), 32'd1);
        chk("rst_araddr", isram_araddr, 32'h8000_0000);
        chk("rst_inst", to_idu_inst, 32'd0);
        chk("rst_pc", to_idu_pc, 32'd0);
        chk("rst_err", 32'(to_idu_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("boot_arvalid", 32'(isram_arvalid), 32'd1);
        chk("boot_araddr", isram_araddr, 32'h8000_0000);

        // Sequential stream, non-OKAY response on the second word
        push_tx(32'h8000_0000, 1'b0); get_one();
        push_tx(32'h8000_0004, 1'b1); get_one();
        push_tx(32'h8000_0008, 1'b0); get_one();
        chk_ar(32'h8000_0000); chk_ar(32'h8000_0004); chk_ar(32'h8000_0008);

        // Decode stall for 5 cycles
        wait_sig("stall_valid", 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(to_idu_valid), 32'd1);
            chk("stall_pc", to_idu_pc, 32'h8000_000C);
            chk("stall_inst", to_idu_inst, mem(32'h8000_000C));
            chk("stall_arvalid", 32'(isram_arvalid), 32'd0);
            @(negedge clk);
        end
        rlat = 4;
        push_tx(32'h8000_000C, 1'b0);
        idu_allowin = 1'b1;
        @(negedge clk);
        idu_allowin = 1'b0;
        chk("resume_arvalid", 32'(isram_arvalid), 32'd1);
        chk("resume_araddr", isram_araddr, 32'h8000_0010);
        chk_ar(32'h8000_000C);

        // Redirect while in S_R
        wait_sig("wait_rready", 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        @(negedge clk);
        redirect_valid = 1'b0;
        push_tx(32'h8000_0100, 1'b0); get_one();
        chk_ar(32'h8000_0010); chk_ar(32'h8000_0100);

        // Two redirects during one in-flight read
        wait_sig("wait_rready", 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
        @(negedge clk);
        redirect_valid = 1'b0;
        rlat = 1;
        push_tx(32'h8000_0300, 1'b0); get_one();
        chk_ar(32'h8000_0104); chk_ar(32'h8000_0300);

        // Redirect and allowin together in S_OUT
        wait_sig("wait_valid", 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0400; idu_allowin = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0; idu_allowin = 1'b0;
        chk("redir_out_valid", 32'(to_idu_valid), 32'd0);
        chk("redir_out_arvalid", 32'(isram_arvalid), 32'd1);
        chk("redir_out_araddr", isram_araddr, 32'h8000_0400);
        push_tx(32'h8000_0400, 1'b0); get_one();
        chk_ar(32'h8000_0304); chk_ar(32'h8000_0400);

        // PC wrap, held address under arready=0, redirect while stuck in S_AR
        wait_sig("wait_valid", 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_sig("wait_valid", 1'b0);
        push_tx(32'hFFFF_FFFC, 1'b0);
        isram_arready = 1'b0;
        idu_allowin = 1'b1;
        @(negedge clk);
        idu_allowin = 1'b0;
        chk("wrap_arvalid", 32'(isram_arvalid), 32'd1);
        chk("wrap_araddr", isram_araddr, 32'h0000_0000);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0500;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("hold_araddr", isram_araddr, 32'h0000_0000);
        @(negedge clk);
        chk("hold_araddr2", isram_araddr, 32'h0000_0000);
        chk("hold_arvalid", 32'(isram_arvalid), 32'd1);
        isram_arready = 1'b1;
        push_tx(32'h8000_0500, 1'b0); get_one();
        chk_ar(32'h8000_0404); chk_ar(32'hFFFF_FFFC); chk_ar(32'h0000_0000); chk_ar(32'h8000_0500);

        // Reset in the middle of S_R
        rlat = 4;
        wait_sig("wait_rready", 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_arvalid", 32'(isram_arvalid), 32'd0);
        chk("mid_rst_rready", 32'(isram_rready), 32'd0);
        chk("mid_rst_araddr", isram_araddr, 32'h8000_0000);
        @(negedge clk);
        rst = 1'b0;
        rlat = 1;
        @(negedge clk);
        chk("reboot_arvalid", 32'(isram_arvalid), 32'd1);
        push_tx(32'h8000_0000, 1'b0); get_one();
        chk_ar(32'h8000_0504); chk_ar(32'h8000_0000);

        // Redirect on the same edge as the AR handshake
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0600;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("ar_redir_rready", 32'(isram_rready), 32'd1);
        push_tx(32'h8000_0600, 1'b0); get_one();
        chk_ar(32'h8000_0004); chk_ar(32'h8000_0600);

        chk("tx_drained", 32'(exp_tx.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
